wf_done_sequencer: RTL and testbench
====================================

Name: wf_done_sequencer

Overview:
- Sequences the release of halted wavefronts back to fetch.
- Tracks a per-WF halted flag set by decode.
- Selects eligible WFs (halted, no instructions inflight, no outstanding memory) with a round-robin arbiter.
- Runs a req/ack handshake with fetch so that exactly one WF-done event is outstanding at a time. It then clears the halted flag and frees the slot.

Parameters:
WF_PER_CU, 40, number of wavefront slots per CU
WF_ID_LENGTH, 6, width of a wavefront id
TIMEOUT_W, 8, width of the ack-timeout counter (used only with the optional feature)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset; rst==0 resets all state immediately
halt_valid  input  1  decode retired an s_endpgm/halt for halt_wfid this cycle
halt_wfid  input  WF_ID_LENGTH  WF being halted
no_inflight_arry  input  WF_PER_CU  per-WF flag: zero instructions inflight
mem_wait_arry  input  WF_PER_CU  per-WF flag: memory ops outstanding
done_ack  input  1  fetch accepted the current done event
done_en  output  1  WF-done request to fetch (registered)
done_wfid  output  WF_ID_LENGTH  WF being reported (registered, stable while done_en=1)
halted_arry  output  WF_PER_CU  current halted flags (registered)
busy  output  1  state != IDLE
timeout_err  output  1  sticky ack-timeout error (optional feature)

Behaviour:
- Reset values: done_en=0, done_wfid=0, halted_arry=0, busy=0, timeout_err=0, state=IDLE, rr_ptr=WF_PER_CU-1 (the first search starts at WF 0).
- Eligibility: elig[i] = halted_arry[i] & no_inflight_arry[i] & ~mem_wait_arry[i].
- Halt set: if halt_valid and halt_wfid < WF_PER_CU, then halted_arry[halt_wfid] is set at the next edge. If halt_wfid >= WF_PER_CU, the event is ignored.
- States: IDLE, REQ, GAP.
- IDLE:
  - If any elig bit is set, pick the first set index searching rr_ptr+1, rr_ptr+2, ... with wrap modulo WF_PER_CU.
  - Register it into done_wfid, set done_en=1 and go to REQ.
  - Latency: elig visible in cycle t gives done_en=1 in cycle t+1.
  - If no elig bit is set, stay in IDLE.
- REQ:
  - done_en is held at 1 and done_wfid is held stable until done_ack=1.
  - Once the request is issued it is never withdrawn, even if elig for that WF drops.
  - When done_ack=1: clear halted_arry[done_wfid] at that edge, set rr_ptr=done_wfid, drive done_en=0 in the next cycle, and go to GAP.
- GAP:
  - Exactly one bubble cycle so that no_inflight/mem_wait can settle.
  - Then go to IDLE.
  - Minimum spacing between two done_en pulses is therefore 3 cycles.
- done_ack while in IDLE or GAP is ignored.
- Same-cycle set and clear of the same WF: the set wins, and halted_arry stays 1. That WF is re-eligible later; this is legal because fetch reuses the slot.
- halt_valid for a WF already halted: no effect.
- Reset asserted mid-handshake: done_en drops asynchronously, all halted flags are lost, state goes to IDLE. Upstream re-dispatches after reset.
- Round-robin fairness: with all WFs continuously eligible, grants cycle 0,1,...,WF_PER_CU-1,0 with no starvation.

Optional Feature:
- Macro: WF_DONE_ACK_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W-bit counter clears on REQ entry and increments each REQ cycle without done_ack.
  - When it reaches all-ones, timeout_err sets (sticky until reset).
  - The handshake still waits for done_ack; there is no forced release.
- Undefined: there is no counter, and timeout_err is tied to 0.

Test Plan:
- Reset then halt_valid wfid=5 with no_inflight[5]=1, mem_wait[5]=0 -> halted_arry[5]=1 next cycle; done_en=1, done_wfid=5 one cycle later; ack -> halted_arry[5]=0, done_en=0 next cycle.
- Halt WFs 3, 7 and 39, all eligible, done_ack tied 1 -> grants in order 3, 7, 39 with 3-cycle spacing; rr_ptr wraps so a new halt on WF 2 is granted after 39.
- Halt WF 10 with mem_wait[10]=1 for 20 cycles -> no done_en; mem_wait drops at cycle 20 -> done_en at cycle 21.
- In REQ for WF 4, hold done_ack=0 for 10 cycles while dropping no_inflight[4] -> done_en and done_wfid=4 stay stable; ack releases.
- halt_valid wfid=4 in the same cycle as done_ack for WF 4 -> halted_arry[4] remains 1 and WF 4 is granted again after GAP; halt_wfid=45 -> ignored.
- Deassert rst during REQ -> done_en=0 immediately and halted_arry=0; with WF_DONE_ACK_TIMEOUT_EN, TIMEOUT_W=4 and no ack for 15 REQ cycles -> timeout_err=1.

Source files
------------

// File: rtl/wf_done_sequencer.sv
// rtl/wf_done_sequencer.sv - releases halted wavefronts back to fetch one at a time
//
// Purpose:
//   Keeps a per-wavefront halted flag set by decode. Picks one eligible
//   wavefront at a time with a round-robin arbiter, where eligible means
//   halted, nothing inflight and no memory outstanding. Reports it to fetch
//   over a req/ack handshake. Clears the halted flag when fetch acknowledges.
//
// Ports:
//   clk_i               clock, all state on rising edge
//   rst_i               asynchronous active-low reset
//   halt_valid_i        decode retired a halt for halt_wfid_i this cycle
//   halt_wfid_i         wavefront being halted
//   no_inflight_arry_i  per-WF: zero instructions inflight
//   mem_wait_arry_i     per-WF: memory ops outstanding
//   done_ack_i          fetch accepted the current done event
//   done_en_o           done request to fetch (registered)
//   done_wfid_o         wavefront being reported (stable while done_en_o=1)
//   halted_arry_o       current halted flags (registered)
//   busy_o              sequencer not idle
//   timeout_err_o       sticky ack-timeout error (optional)
//
// Optional feature macro: WF_DONE_ACK_TIMEOUT_EN (ack-timeout counter).

module wf_done_sequencer #(
    parameter int WF_PER_CU    = 40,
    parameter int WF_ID_LENGTH = 6,
    parameter int TIMEOUT_W    = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    halt_valid_i,
    input  logic [WF_ID_LENGTH-1:0] halt_wfid_i,
    input  logic [WF_PER_CU-1:0]    no_inflight_arry_i,
    input  logic [WF_PER_CU-1:0]    mem_wait_arry_i,
    input  logic                    done_ack_i,
    output logic                    done_en_o,
    output logic [WF_ID_LENGTH-1:0] done_wfid_o,
    output logic [WF_PER_CU-1:0]    halted_arry_o,
    output logic                    busy_o,
    output logic                    timeout_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e                  state_q;
    logic                    done_en_q;
    logic [WF_ID_LENGTH-1:0] done_wfid_q;
    logic [WF_ID_LENGTH-1:0] rr_ptr_q;
    logic [WF_PER_CU-1:0]    halted_q;
    logic [WF_PER_CU-1:0]    halted_d;

    logic [WF_PER_CU-1:0]    elig;
    logic                    any_elig;
    logic [WF_ID_LENGTH-1:0] pick;
    logic                    release_w;

    assign elig      = halted_q & no_inflight_arry_i & ~mem_wait_arry_i;
    assign release_w = (state_q == ST_REQ) && done_ack_i;

    // Round-robin pick: first eligible index above rr_ptr, otherwise the
    // first eligible index at or below it (the wrapped part of the search).
    always_comb begin
        logic                    hi_found;
        logic                    lo_found;
        logic [WF_ID_LENGTH-1:0] hi_pick;
        logic [WF_ID_LENGTH-1:0] lo_pick;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_pick  = '0;
        lo_pick  = '0;
        for (int i = 0; i < WF_PER_CU; i++) begin
            if (elig[i] && (i > int'(rr_ptr_q)) && !hi_found) begin
                hi_found = 1'b1;
                hi_pick  = WF_ID_LENGTH'(i);
            end
            if (elig[i] && (i <= int'(rr_ptr_q)) && !lo_found) begin
                lo_found = 1'b1;
                lo_pick  = WF_ID_LENGTH'(i);
            end
        end
        any_elig = hi_found | lo_found;
        pick     = hi_found ? hi_pick : lo_pick;
    end

    // Halted flag update. The set is applied after the clear so a halt for
    // the WF being released in the same cycle keeps its flag. Out-of-range
    // halt ids match no slot and are dropped.
    always_comb begin
        halted_d = halted_q;
        for (int i = 0; i < WF_PER_CU; i++) begin
            if (release_w && (int'(done_wfid_q) == i)) begin
                halted_d[i] = 1'b0;
            end
            if (halt_valid_i && (int'(halt_wfid_i) == i)) begin
                halted_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            done_en_q   <= 1'b0;
            done_wfid_q <= '0;
            rr_ptr_q    <= WF_ID_LENGTH'(WF_PER_CU - 1);
            halted_q    <= '0;
        end else begin
            halted_q <= halted_d;
            case (state_q)
                ST_IDLE: begin
                    if (any_elig) begin
                        done_wfid_q <= pick;
                        done_en_q   <= 1'b1;
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // The request is never withdrawn; only the ack ends it.
                    if (done_ack_i) begin
                        done_en_q <= 1'b0;
                        rr_ptr_q  <= done_wfid_q;
                        state_q   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // One bubble so the per-WF status inputs can settle.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    done_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign done_en_o     = done_en_q;
    assign done_wfid_o   = done_wfid_q;
    assign halted_arry_o = halted_q;
    assign busy_o        = (state_q != ST_IDLE);

`ifdef WF_DONE_ACK_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_q;
    logic [TIMEOUT_W-1:0] tmo_inc;
    logic                 timeout_err_q;

    assign tmo_inc = tmo_cnt_q + 1'b1;

    // Counts REQ cycles without an ack; saturates at all-ones. The error
    // is report-only and sticky, the handshake keeps waiting for the ack.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && any_elig) begin
                tmo_cnt_q <= '0;
            end else if ((state_q == ST_REQ) && !done_ack_i && !(&tmo_cnt_q)) begin
                tmo_cnt_q <= tmo_inc;
                if (&tmo_inc) begin
                    timeout_err_q <= 1'b1;
                end
            end
        end
    end

    assign timeout_err_o = timeout_err_q;
`else
    localparam int unused_timeout_w = TIMEOUT_W;
    assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wf_done_sequencer.sv
// tb/tb_wf_done_sequencer.sv - self-checking bench for wf_done_sequencer
module tb_wf_done_sequencer;

    localparam int N = 40;
    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         halt_valid;
    logic [W-1:0] halt_wfid;
    logic [N-1:0] no_inflight;
    logic [N-1:0] mem_wait;
    logic         done_ack;
    logic         done_en;
    logic [W-1:0] done_wfid;
    logic [N-1:0] halted;
    logic         busy;
    logic         timeout_err;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [W-1:0] exp_q[$];
    int           grant_cyc[$];

    wf_done_sequencer #(.WF_PER_CU(N), .WF_ID_LENGTH(W), .TIMEOUT_W(8)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .halt_valid_i       (halt_valid),
        .halt_wfid_i        (halt_wfid),
        .no_inflight_arry_i (no_inflight),
        .mem_wait_arry_i    (mem_wait),
        .done_ack_i         (done_ack),
        .done_en_o          (done_en),
        .done_wfid_o        (done_wfid),
        .halted_arry_o      (halted),
        .busy_o             (busy),
        .timeout_err_o      (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard monitor: every new request pops the expected WF id, and
    // the id must stay put while the request is held.
    logic         prev_en = 1'b0;
    logic [W-1:0] held_id = '0;
    always @(negedge clk) begin
        logic [W-1:0] exp_id;
        if (!rst) begin
            prev_en = 1'b0;
        end else begin
            if (done_en && !prev_en) begin
                vectors++;
                grant_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL grant_unexpected: got done_wfid=%0d, required no grant", done_wfid);
                end else begin
                    exp_id = exp_q.pop_front();
                    if (done_wfid !== exp_id) begin
                        miscompares++;
                        $display("FAIL grant_order: got done_wfid=%0d, required %0d", done_wfid, exp_id);
                    end
                end
                held_id = done_wfid;
            end else if (done_en && prev_en) begin
                vectors++;
                if (done_wfid !== held_id) begin
                    miscompares++;
                    $display("FAIL grant_stable: got done_wfid=%0d, required %0d", done_wfid, held_id);
                end
            end
            prev_en = done_en;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic halt(input int id);
        halt_valid = 1'b1;
        halt_wfid  = W'(id);
        tick();
        halt_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d grants still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rst         = 1'b0;
        halt_valid  = 1'b0;
        halt_wfid   = '0;
        no_inflight = '1;
        mem_wait    = '0;
        done_ack    = 1'b0;
        repeat (2) tick();
        vectors++;
        if ({done_en, done_wfid, halted, busy, timeout_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_values: got en=%b id=%0d halted=%h busy=%b terr=%b, required all 0",
                     done_en, done_wfid, halted, busy, timeout_err);
        end
        rst = 1'b1;
        repeat (2) tick();
        vectors++;
        if (done_en !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got en=%b busy=%b, required 0 0", done_en, busy);
        end
    endtask

    task automatic test_basic;
        exp_q.push_back(W'(5));
        halt(5);
        vectors++;
        if (halted[5] !== 1'b1 || done_en !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_halt_set: got halted[5]=%b en=%b, required 1 0", halted[5], done_en);
        end
        tick();
        vectors++;
        if (done_en !== 1'b1 || done_wfid !== W'(5)) begin
            miscompares++;
            $display("FAIL basic_req: got en=%b id=%0d, required 1 5", done_en, done_wfid);
        end
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        vectors++;
        if (done_en !== 1'b0 || halted[5] !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_release: got en=%b halted[5]=%b busy=%b, required 0 0 1",
                     done_en, halted[5], busy);
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_gap_end: got busy=%b, required 0", busy);
        end
        wait_drain("basic", 10);
    endtask

    task automatic test_round_robin;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        grant_cyc.delete();
        done_ack = 1'b1;
        exp_q.push_back(W'(3));
        exp_q.push_back(W'(7));
        exp_q.push_back(W'(39));
        exp_q.push_back(W'(2));
        halt(3);
        halt(7);
        halt(39);
        halt(2);
        wait_drain("rr", 40);
        repeat (2) tick();
        done_ack = 1'b0;
        vectors++;
        if (grant_cyc.size() != 4) begin
            miscompares++;
            $display("FAIL rr_grant_count: got %0d grants, required 4", grant_cyc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                vectors++;
                if (grant_cyc[i] - grant_cyc[i-1] != 3) begin
                    miscompares++;
                    $display("FAIL rr_spacing: grant %0d got spacing %0d, required 3",
                             i, grant_cyc[i] - grant_cyc[i-1]);
                end
            end
        end
        vectors++;
        if (halted !== '0) begin
            miscompares++;
            $display("FAIL rr_all_released: got halted=%h, required 0", halted);
        end
    endtask

    task automatic test_mem_wait;
        int bad = 0;
        mem_wait[10] = 1'b1;
        exp_q.push_back(W'(10));
        halt(10);
        repeat (20) begin
            tick();
            if (done_en !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL memwait_blocks: got %0d cycles with done_en=1, required 0", bad);
        end
        mem_wait[10] = 1'b0;
        tick();
        vectors++;
        if (done_en !== 1'b1 || done_wfid !== W'(10)) begin
            miscompares++;
            $display("FAIL memwait_release: got en=%b id=%0d, required 1 10", done_en, done_wfid);
        end
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        tick();
        wait_drain("memwait", 10);
    endtask

    task automatic test_hold;
        int bad = 0;
        exp_q.push_back(W'(4));
        halt(4);
        tick();
        no_inflight[4] = 1'b0;
        repeat (10) begin
            tick();
            if (done_en !== 1'b1 || done_wfid !== W'(4) || timeout_err !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL hold_stable: got %0d unstable cycles, required 0", bad);
        end
        no_inflight[4] = 1'b1;
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        vectors++;
        if (done_en !== 1'b0 || halted[4] !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_release: got en=%b halted[4]=%b, required 0 0", done_en, halted[4]);
        end
        tick();
        wait_drain("hold", 10);
    endtask

    task automatic test_set_clear_collide;
        int bad = 0;
        exp_q.push_back(W'(4));
        exp_q.push_back(W'(4));
        halt(4);
        tick();
        done_ack   = 1'b1;
        halt_valid = 1'b1;
        halt_wfid  = W'(4);
        tick();
        done_ack   = 1'b0;
        halt_valid = 1'b0;
        vectors++;
        if (halted[4] !== 1'b1 || done_en !== 1'b0) begin
            miscompares++;
            $display("FAIL collide_set_wins: got halted[4]=%b en=%b, required 1 0", halted[4], done_en);
        end
        repeat (2) tick();
        vectors++;
        if (done_en !== 1'b1 || done_wfid !== W'(4)) begin
            miscompares++;
            $display("FAIL collide_regrant: got en=%b id=%0d, required 1 4", done_en, done_wfid);
        end
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        tick();
        halt(45);
        vectors++;
        if (halted !== '0) begin
            miscompares++;
            $display("FAIL halt_out_of_range: got halted=%h, required 0", halted);
        end
        repeat (3) begin
            tick();
            if (done_en !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL out_of_range_no_grant: got %0d grant cycles, required 0", bad);
        end
        wait_drain("collide", 10);
    endtask

    task automatic test_reset_midreq;
        exp_q.push_back(W'(9));
        halt(9);
        tick();
        vectors++;
        if (done_en !== 1'b1) begin
            miscompares++;
            $display("FAIL midreq_entry: got en=%b, required 1", done_en);
        end
        #6;
        rst = 1'b0;
        #1;
        vectors++;
        if (done_en !== 1'b0 || halted !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreq_async_reset: got en=%b halted=%h busy=%b, required 0 0 0",
                     done_en, halted, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) tick();
        vectors++;
        if (done_en !== 1'b0) begin
            miscompares++;
            $display("FAIL midreq_no_regrant: got en=%b, required 0", done_en);
        end
        wait_drain("midreq", 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_mem_wait();
        test_hold();
        test_set_clear_collide();
        test_reset_midreq();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
